rdma_scatter_seq: RTL and testbench
===================================

Name: rdma_scatter_seq

Overview:
- Sequences one scatter operation per incoming RDMA write.
- Snapshots the four host-programmed destination vaddrs. For each destination in turn, it issues one local write descriptor, then forwards exactly one quarter of the payload beats with tlast regenerated at each chunk boundary.
- Sits between the scatter control-register parser (vaddr source), the RDMA receive stream and the local write-queue/data path.

Parameters:
- VADDR_BITS, 48, width of destination virtual addresses
- LEN_BITS, 28, width of byte-length fields
- DATA_BITS, 512, AXI-Stream data width; BEAT_BYTES = DATA_BITS/8
- N_DEST, 4, number of scatter destinations (fixed at 4 for this block)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- vaddr_1 .. vaddr_4  in  VADDR_BITS each  destination vaddrs from the control parser
- vaddr_valid  in  1  all four vaddrs programmed
- req_valid  in  1  new RDMA write request
- req_ready  out  1  request accepted
- req_len  in  LEN_BITS  total payload bytes
- sq_valid  out  1  local write descriptor valid
- sq_ready  in  1  descriptor accepted
- sq_vaddr  out  VADDR_BITS  descriptor destination
- sq_len  out  LEN_BITS  descriptor byte length (req_len/4)
- sq_last  out  1  descriptor is for destination 4
- s_axis_tdata  in  DATA_BITS  payload in
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- s_axis_tlast  in  1  payload last
- m_axis_tdata  out  DATA_BITS  payload out
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  chunk boundary
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at operation end
- err_cnt  out  16  saturating error counter

Behaviour:
- Reset (asynchronous, active-low, applied immediately):
  - state = IDLE, idx = 0, beat counter = 0, err_cnt = 0.
  - All valid/ready outputs, busy and done are 0.
  - The snapshot registers are cleared to 0.
  - Reset mid-operation abandons it; no descriptor or beat is replayed after reset.
- States: IDLE, ISSUE, STREAM, DRAIN.
- IDLE:
  - req_ready = vaddr_valid.
  - On req_valid & req_ready: snapshot vaddr_1..4, compute chunk_len = req_len >> 2 and chunk_beats = chunk_len / BEAT_BYTES.
  - req_len is legal only if it is nonzero and a multiple of 4*BEAT_BYTES.
  - If legal: idx = 0, go to ISSUE.
  - If illegal: err_cnt++, go to DRAIN.
- ISSUE:
  - sq_valid = 1; sq_vaddr = snapshot[idx]; sq_len = chunk_len; sq_last = (idx == 3).
  - The descriptor is held stable until sq_ready.
  - On the handshake: beat counter = 0, go to STREAM.
  - Latency from request accept to first sq_valid is 1 cycle.
- STREAM:
  - Combinational pass-through: m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready, tdata unchanged.
  - m_axis_tlast = (beat counter == chunk_beats - 1).
  - The beat counter advances on each output handshake.
  - On the last beat of a chunk: if idx == 3, pulse done and go to IDLE; otherwise idx++ and go to ISSUE. Payload is stalled (s_axis_tready = 0) while in ISSUE.
  - Input tlast check: s_axis_tlast is expected only on the final beat of chunk 4. If it is seen on any other beat, or missing on that final beat, err_cnt++; the beat is still forwarded and the sequence continues by count.
- DRAIN (illegal length):
  - s_axis_tready = 1, m_axis_tvalid = 0; input beats are discarded.
  - Exit to IDLE on the input beat with tlast; no descriptors are issued.
- Outputs outside their state:
  - sq_valid = 0 outside ISSUE.
  - m_axis_tvalid = 0 outside STREAM.
  - s_axis_tready = 0 in IDLE and ISSUE.
- busy = (state != IDLE).
- Changes to vaddr_1..4 or vaddr_valid during an operation are ignored (snapshot).
- err_cnt saturates at 16'hFFFF.
- Width rule: sq_len is req_len >> 2, truncation-free because legality is checked first.
- Back-to-back requests: the next request can be accepted in the cycle after done.

Decomposition:
- lynxTypes supplies VADDR_BITS, LEN_BITS and the AXI data width.
- State enum and a descriptor struct (vaddr, len, last) go in a shared package, rdma_scatter_pkg.
- One natural sub-module: rdma_scatter_beat_cnt. It holds the chunk-beat counter and the tlast-generation/check logic.

Test Plan:
- Nominal: vaddrs 0x1000/0x2000/0x3000/0x4000, vaddr_valid = 1, req_len = 1024 (BEAT_BYTES = 64), 16 input beats with tlast on beat 16 -> 4 descriptors (0x1000,256) .. (0x4000,256) with sq_last only on the fourth; m_axis_tlast on output beats 4, 8, 12, 16; done pulses once; err_cnt = 0.
- Backpressure: same request, sq_ready delayed 5 cycles per descriptor and m_axis_tready toggling every cycle -> identical output beat order and data, no beat lost or duplicated, descriptor held stable while stalled.
- Illegal length: req_len = 100 followed by 2 input beats, tlast on beat 2 -> no sq_valid; both beats consumed with m_axis_tvalid = 0; err_cnt = 1; FSM returns to IDLE.
- Gating/snapshot: vaddr_valid = 0 with req_valid = 1 -> req_ready stays 0. Then vaddr_valid = 1 and accept; change vaddr_3 to 0x9000 mid-operation -> third descriptor still uses 0x3000.
- Protocol error: req_len = 1024 with input tlast on beat 8 -> err_cnt = 1, all 16 beats still forwarded with the correct chunk tlasts.
- Reset mid-STREAM: assert aresetn = 0 during chunk 2 -> all outputs 0 asynchronously. After release: IDLE, err_cnt = 0, and a new request runs the nominal sequence.

Source files
------------

// File: rtl/rdma_scatter_pkg.sv
// Shared types and widths for the RDMA scatter sequencer.
// Default widths mirror the lynx platform types (vaddr, length, AXI data).
package rdma_scatter_pkg;

    localparam int LYNX_VADDR_BITS = 48;
    localparam int LYNX_LEN_BITS   = 28;
    localparam int LYNX_DATA_BITS  = 512;
    localparam int SCATTER_N_DEST  = 4;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } scatter_state_t;

    // One local write descriptor as presented on the sq_* interface.
    typedef struct packed {
        logic [LYNX_VADDR_BITS-1:0] vaddr;
        logic [LYNX_LEN_BITS-1:0]   len;
        logic                       last;
    } sq_desc_t;

    // A request length is usable only if it is nonzero and splits into four
    // whole-beat chunks, i.e. the low align_bits bits are all zero.
    function automatic logic len_is_legal(input logic [LYNX_LEN_BITS-1:0] len,
                                          input int                       align_bits);
        logic [LYNX_LEN_BITS-1:0] mask;
        mask = (LYNX_LEN_BITS'(1) << align_bits) - LYNX_LEN_BITS'(1);
        return (len != '0) && ((len & mask) == '0);
    endfunction

endpackage

// File: rtl/rdma_scatter_beat_cnt.sv
// Chunk beat counter: marks the last beat of each chunk and checks the
// upstream tlast against the only place it is allowed (end of chunk 4).
module rdma_scatter_beat_cnt
    import rdma_scatter_pkg::*;
#(
    parameter int LEN_BITS = LYNX_LEN_BITS
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                clear,
    input  logic                advance,
    input  logic [LEN_BITS-1:0] chunk_beats,
    input  logic                final_chunk,
    input  logic                s_tlast,
    output logic                chunk_tlast,
    output logic                tlast_err
);

    logic [LEN_BITS-1:0] beat_cnt;

    assign chunk_tlast = (beat_cnt == (chunk_beats - LEN_BITS'(1)));

    // Upstream tlast must coincide exactly with the final beat of the final chunk.
    assign tlast_err = advance && (s_tlast != (chunk_tlast && final_chunk));

    // Count forwarded beats within the current chunk; restart per descriptor.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= chunk_tlast ? '0 : beat_cnt + LEN_BITS'(1);
        end
    end

endmodule

// File: rtl/rdma_scatter_seq.sv
// RDMA scatter sequencer: splits one incoming RDMA write into four equal
// chunks, issuing a local write descriptor ahead of each chunk.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready follows vaddr_valid
// ISSUE  | presenting descriptor for destination idx, payload stalled
// STREAM | forwarding the current chunk, tlast regenerated per chunk
// DRAIN  | illegal length: swallow input up to and including tlast
module rdma_scatter_seq
    import rdma_scatter_pkg::*;
#(
    parameter int VADDR_BITS = LYNX_VADDR_BITS,
    parameter int LEN_BITS   = LYNX_LEN_BITS,
    parameter int DATA_BITS  = LYNX_DATA_BITS,
    parameter int N_DEST     = SCATTER_N_DEST
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [VADDR_BITS-1:0] vaddr_1,
    input  logic [VADDR_BITS-1:0] vaddr_2,
    input  logic [VADDR_BITS-1:0] vaddr_3,
    input  logic [VADDR_BITS-1:0] vaddr_4,
    input  logic                  vaddr_valid,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LEN_BITS-1:0]   req_len,
    output logic                  sq_valid,
    input  logic                  sq_ready,
    output logic [VADDR_BITS-1:0] sq_vaddr,
    output logic [LEN_BITS-1:0]   sq_len,
    output logic                  sq_last,
    input  logic [DATA_BITS-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_BITS-1:0]  m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_cnt
);

    localparam int BEAT_BYTES = DATA_BITS / 8;
    // Four chunks of whole beats: chunk_beats = req_len >> (2 + log2(BEAT_BYTES)).
    localparam int ALIGN_BITS = $clog2(BEAT_BYTES) + 2;
    localparam logic [1:0] LAST_IDX = 2'(N_DEST - 1);

    scatter_state_t        state, state_nxt;
    logic [1:0]            idx;
    logic [VADDR_BITS-1:0] snap [N_DEST];
    logic [LEN_BITS-1:0]   chunk_len;
    logic [LEN_BITS-1:0]   chunk_beats;
    logic                  tlast_err_seen;

    logic     req_accept;
    logic     req_legal;
    logic     beat_adv;
    logic     beat_clear;
    logic     chunk_tlast;
    logic     chunk_done;
    logic     final_chunk;
    logic     tlast_err;
    logic     err_inc;
    sq_desc_t desc;

    assign req_legal   = len_is_legal(req_len, ALIGN_BITS);
    assign req_accept  = (state == ST_IDLE) && req_valid && vaddr_valid;
    assign beat_adv    = (state == ST_STREAM) && s_axis_tvalid && m_axis_tready;
    assign beat_clear  = (state == ST_ISSUE) && sq_ready;
    assign final_chunk = (idx == LAST_IDX);
    assign chunk_done  = beat_adv && chunk_tlast;

    // Only the first tlast mismatch of an operation is counted; later beats of
    // the same broken stream would otherwise inflate the counter.
    assign err_inc = (req_accept && !req_legal) || (tlast_err && !tlast_err_seen);

    rdma_scatter_beat_cnt #(
        .LEN_BITS (LEN_BITS)
    ) u_beat_cnt (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .clear       (beat_clear),
        .advance     (beat_adv),
        .chunk_beats (chunk_beats),
        .final_chunk (final_chunk),
        .s_tlast     (s_axis_tlast),
        .chunk_tlast (chunk_tlast),
        .tlast_err   (tlast_err)
    );

    // Descriptor for the current destination, held stable by the registers behind it.
    always_comb begin
        desc       = '0;
        desc.vaddr = snap[idx];
        desc.len   = chunk_len;
        desc.last  = final_chunk;
    end

    assign sq_vaddr = desc.vaddr;
    assign sq_len   = desc.len;
    assign sq_last  = desc.last;
    assign busy     = (state != ST_IDLE);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot the destinations at accept so host reprogramming cannot disturb a run.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_DEST; i++) begin
                snap[i] <= '0;
            end
            chunk_len   <= '0;
            chunk_beats <= '0;
        end else if (req_accept) begin
            snap[0]     <= vaddr_1;
            snap[1]     <= vaddr_2;
            snap[2]     <= vaddr_3;
            snap[3]     <= vaddr_4;
            chunk_len   <= req_len >> 2;
            chunk_beats <= req_len >> ALIGN_BITS;
        end
    end

    // Destination index: restarts on accept, steps after each non-final chunk.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx <= '0;
        end else if (req_accept) begin
            idx <= '0;
        end else if (chunk_done && !final_chunk) begin
            idx <= idx + 2'd1;
        end
    end

    // Saturating error counter plus per-operation tlast error latch.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt        <= '0;
            tlast_err_seen <= 1'b0;
        end else begin
            if (req_accept) begin
                tlast_err_seen <= 1'b0;
            end else if (tlast_err) begin
                tlast_err_seen <= 1'b1;
            end
            if (err_inc && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    // Next-state and handshake outputs; payload is a pure pass-through in STREAM.
    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        sq_valid      = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        done          = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = vaddr_valid;
                if (req_accept) begin
                    state_nxt = req_legal ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                sq_valid = 1'b1;
                if (sq_ready) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = chunk_tlast;
                if (chunk_done) begin
                    if (final_chunk) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rdma_scatter_seq.sv
// Directed and randomized bench for rdma_scatter_seq with a queue-based
// reference model: expected descriptors, beats and chunk tlasts are derived
// from the request length and vaddrs with plain arithmetic.
module tb_rdma_scatter_seq;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [47:0]  vaddr_1 = '0, vaddr_2 = '0, vaddr_3 = '0, vaddr_4 = '0;
    logic         vaddr_valid = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [27:0]  req_len = '0;
    logic         sq_valid;
    logic         sq_ready = 1'b0;
    logic [47:0]  sq_vaddr;
    logic [27:0]  sq_len;
    logic         sq_last;
    logic [511:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;
    logic         busy;
    logic         done;
    logic [15:0]  err_cnt;

    always #5 aclk = ~aclk;

    rdma_scatter_seq dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .vaddr_1       (vaddr_1),
        .vaddr_2       (vaddr_2),
        .vaddr_3       (vaddr_3),
        .vaddr_4       (vaddr_4),
        .vaddr_valid   (vaddr_valid),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_len       (req_len),
        .sq_valid      (sq_valid),
        .sq_ready      (sq_ready),
        .sq_vaddr      (sq_vaddr),
        .sq_len        (sq_len),
        .sq_last       (sq_last),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .err_cnt       (err_cnt)
    );

    int checks = 0;
    int failures = 0;

    logic [47:0]  va [4];
    logic [511:0] in_data [$];
    logic [511:0] exp_data [$];
    logic [511:0] got_data [$];
    bit           exp_tlast [$];
    bit           got_tlast [$];
    logic [76:0]  exp_desc [$];
    logic [76:0]  got_desc [$];
    int           exp_err = 0;
    int           exp_done = 0;
    int           done_cnt = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one request through the DUT while collecting its descriptors and beats.
    task automatic run_op(input string name, input logic [27:0] len, input int n_beats,
                          input int tlast_pos, input int sq_delay, input bit tog_ready,
                          input bit rnd, input bit mutate, input int abort_at);
        int k = 0;
        int cyc = 0;
        int sq_wait = 0;
        int chunk_beats;
        bit consumed, acc_now, legal, finished, aborted, hold_pending, mism;
        logic [76:0]  hold_desc, cur_desc;
        logic [511:0] d;

        legal = (len != 0) && (len % 256 == 0);
        in_data.delete();  exp_data.delete(); exp_tlast.delete(); exp_desc.delete();
        got_data.delete(); got_tlast.delete(); got_desc.delete();
        for (int i = 0; i < n_beats; i++) begin
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
            in_data.push_back(d);
        end
        if (legal) begin
            chunk_beats = int'(len) / 256;
            for (int i = 0; i < 4; i++) exp_desc.push_back({va[i], len >> 2, (i == 3)});
            mism = 1'b0;
            for (int i = 0; i < n_beats; i++) begin
                exp_data.push_back(in_data[i]);
                exp_tlast.push_back(((i + 1) % chunk_beats) == 0);
                if ((i == tlast_pos) != (i == n_beats - 1)) mism = 1'b1;
            end
            if (mism && exp_err < 65535) exp_err++;
            exp_done++;
        end else if (exp_err < 65535) begin
            exp_err++;
        end

        vaddr_1 = va[0]; vaddr_2 = va[1]; vaddr_3 = va[2]; vaddr_4 = va[3];
        req_len = len; req_valid = 1'b1;
        s_axis_tdata = in_data[0]; s_axis_tlast = (tlast_pos == 0); s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1; sq_ready = 1'b0;
        finished = 1'b0; aborted = 1'b0; hold_pending = 1'b0;

        while (!finished && cyc < 600) begin
            @(negedge aclk);
            acc_now  = req_valid && req_ready;
            consumed = s_axis_tvalid && s_axis_tready;
            cur_desc = {sq_vaddr, sq_len, sq_last};
            if (hold_pending && sq_valid) check({name, ".sq_hold"}, cur_desc, hold_desc);
            hold_pending = sq_valid && !sq_ready;
            hold_desc = cur_desc;
            if (sq_valid && sq_ready) got_desc.push_back(cur_desc);
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_tlast.push_back(m_axis_tlast);
            end
            if (done) done_cnt++;
            @(posedge aclk); #1; cyc++;
            if (acc_now) begin
                req_valid = 1'b0;
                check({name, ".sq_latency"}, sq_valid, legal);
            end
            if (consumed) k++;
            if (mutate && k == 6) vaddr_3 = 48'h9000;
            if (k >= n_beats) begin
                s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; finished = 1'b1;
            end else if (abort_at >= 0 && k >= abort_at) begin
                finished = 1'b1; aborted = 1'b1;
            end else begin
                if (consumed || !s_axis_tvalid) begin
                    s_axis_tdata  = in_data[k];
                    s_axis_tlast  = (k == tlast_pos);
                    s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (sq_valid) begin
                    sq_ready = (sq_wait >= sq_delay);
                    sq_wait++;
                end else begin
                    sq_ready = 1'b0;
                    sq_wait = 0;
                end
                m_axis_tready = tog_ready ? !m_axis_tready :
                                (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            end
        end
        if (!aborted) check({name, ".beats_consumed"}, k, n_beats);
        sq_ready = 1'b0;
    endtask

    // Compare collected traffic and status against the model.
    task automatic compare_op(input string name);
        check({name, ".desc_count"}, got_desc.size(), exp_desc.size());
        for (int i = 0; i < exp_desc.size() && i < got_desc.size(); i++)
            check($sformatf("%s.desc%0d", name, i), got_desc[i], exp_desc[i]);
        check({name, ".beat_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s.data%0d", name, i), got_data[i], exp_data[i]);
            check($sformatf("%s.tlast%0d", name, i), got_tlast[i], exp_tlast[i]);
        end
        check({name, ".err_cnt"}, err_cnt, exp_err);
        check({name, ".done_cnt"}, done_cnt, exp_done);
        check({name, ".busy_after"}, busy, 1'b0);
    endtask

    task automatic set_nominal_vaddrs();
        va[0] = 48'h1000; va[1] = 48'h2000; va[2] = 48'h3000; va[3] = 48'h4000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, tp;
        logic [27:0] rlen;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst.busy", busy, 1'b0);
        check("rst.sq_valid", sq_valid, 1'b0);
        check("rst.m_tvalid", m_axis_tvalid, 1'b0);
        check("rst.s_tready", s_axis_tready, 1'b0);
        check("rst.req_ready", req_ready, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.err_cnt", err_cnt, 16'h0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Nominal
        set_nominal_vaddrs();
        vaddr_valid = 1'b1;
        run_op("nominal", 28'd1024, 16, 15, 0, 1'b0, 1'b0, 1'b0, -1);
        compare_op("nominal");

        // Backpressure on descriptors and output
        run_op("bp", 28'd1024, 16, 15, 5, 1'b1, 1'b0, 1'b0, -1);
        compare_op("bp");

        // Illegal length is drained
        run_op("illegal", 28'd100, 2, 1, 0, 1'b0, 1'b0, 1'b0, -1);
        compare_op("illegal");

        // Gating on vaddr_valid
        vaddr_valid = 1'b0; req_valid = 1'b1; req_len = 28'd1024;
        repeat (3) begin
            @(negedge aclk);
            check("gate.req_ready", req_ready, 1'b0);
            check("gate.busy", busy, 1'b0);
        end
        @(posedge aclk); #1;
        req_valid = 1'b0; vaddr_valid = 1'b1;

        // Snapshot survives vaddr_3 change mid-operation
        run_op("snap", 28'd1024, 16, 15, 1, 1'b0, 1'b0, 1'b1, -1);
        compare_op("snap");
        vaddr_3 = va[2];

        // Protocol error: early tlast on beat 8
        run_op("proto", 28'd1024, 16, 7, 0, 1'b0, 1'b0, 1'b0, -1);
        compare_op("proto");

        // Smallest legal length: one beat per chunk
        run_op("min_len", 28'd256, 4, 3, 2, 1'b0, 1'b0, 1'b0, -1);
        compare_op("min_len");

        // Randomized legal operations
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) va[i] = {$urandom_range(0, 65535), $urandom} & 48'hFFFF_FFFF_FFC0;
            rlen = 28'(256 * $urandom_range(1, 4));
            nb = int'(rlen) / 64;
            tp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : nb - 1;
            run_op($sformatf("rand%0d", r), rlen, nb, tp, $urandom_range(0, 3), 1'b0, 1'b1, 1'b0, -1);
            compare_op($sformatf("rand%0d", r));
        end

        // Reset in the middle of chunk 2
        set_nominal_vaddrs();
        run_op("midrst", 28'd1024, 16, 15, 0, 1'b0, 1'b0, 1'b0, 6);
        #2 aresetn = 1'b0;
        #1;
        check("midrst.sq_valid", sq_valid, 1'b0);
        check("midrst.m_tvalid", m_axis_tvalid, 1'b0);
        check("midrst.s_tready", s_axis_tready, 1'b0);
        check("midrst.busy", busy, 1'b0);
        check("midrst.done", done, 1'b0);
        check("midrst.err_cnt", err_cnt, 16'h0);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        exp_err = 0; exp_done = 0; done_cnt = 0;
        @(posedge aclk); #1;
        check("postrst.busy", busy, 1'b0);
        check("postrst.err_cnt", err_cnt, 16'h0);
        run_op("postrst", 28'd1024, 16, 15, 0, 1'b0, 1'b0, 1'b0, -1);
        compare_op("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
